// File: rtl/i2c_target_ctl_pkg.sv
// Shared definitions for the I2C target byte engine: state encodings, pad
// output-enable levels and the address compare helper.
package i2c_target_ctl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRx,
        StRxAck,
        StTxWait,
        StTx,
        StTxAck
    } tgt_state_e;

    localparam logic OenRelease = 1'b1;
    localparam logic OenDrive   = 1'b0;

    // Address 7'h00 is the general call and is never claimed.
    function automatic logic addr_hit(logic [7:0] addr_byte, logic [6:0] own_addr);
        return (own_addr != 7'h00) && (addr_byte[7:1] == own_addr);
    endfunction

endpackage

// File: rtl/i2c_target_ctl_if.sv
// Host-side handshake between the I2C target engine (slave) and the
// register front end (master).
interface i2c_target_ctl_if;
    logic       ack_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       addr_match;
    logic       rw;
    logic       busy;
    logic       stop;
    logic       master_nack;

    modport slave (
        input  ack_en, tx_data, tx_valid,
        output rx_data, rx_valid, tx_req, addr_match, rw, busy, stop, master_nack
    );

    modport master (
        output ack_en, tx_data, tx_valid,
        input  rx_data, rx_valid, tx_req, addr_match, rw, busy, stop, master_nack
    );
endinterface

// File: rtl/i2c_target_ctl_in_filter.sv
// Pad input conditioning: 2-flop synchroniser followed by a stable-count
// filter; the output only follows after FILT_LEN consecutive equal samples.
module i2c_target_ctl_in_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic sysclk_i,
    input  logic reset_n_i,
    input  logic in_i,
    output logic filt_o
);

    localparam int unsigned CntW = $clog2(FILT_LEN) + 1;

    logic            sync1_q, sync2_q, filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CntW'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge sysclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/i2c_target_ctl.sv
// I2C target byte engine: bus condition detect, address match, RX/TX byte
// shifting and SCL stretching while the host supplies TX data.
module i2c_target_ctl
    import i2c_target_ctl_pkg::*;
#(
    parameter int unsigned FILT_LEN  = 3,
    parameter int unsigned SETUP_CNT = 4
) (
    input  logic              sysclk_i,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic [6:0]        own_addr_i,
    input  logic              scl_i,
    output logic              scl_oen_o,
    input  logic              sda_i,
    output logic              sda_oen_o,
    i2c_target_ctl_if.slave   host_io
);

    localparam int unsigned SetupW = $clog2(SETUP_CNT + 1);

    logic scl_f, sda_f;

    i2c_target_ctl_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .sysclk_i  (sysclk_i),
        .reset_n_i (reset_n_i),
        .in_i      (scl_i),
        .filt_o    (scl_f)
    );

    i2c_target_ctl_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .sysclk_i  (sysclk_i),
        .reset_n_i (reset_n_i),
        .in_i      (sda_i),
        .filt_o    (sda_f)
    );

    tgt_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic [SetupW-1:0] setup_cnt_q, setup_cnt_d;
    logic              scl_prev_q, sda_prev_q;
    logic              rw_q, rw_d, busy_q, busy_d;
    logic              scl_oen_q, scl_oen_d, sda_oen_q, sda_oen_d;
    logic              tx_req_q, tx_req_d, loaded_q, loaded_d, ack_phase_q, ack_phase_d;
    logic              rx_valid_q, rx_valid_d, addr_match_q, addr_match_d;
    logic              stop_q, stop_d, nack_q, nack_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    // Bus conditions need SCL high on both sides of the SDA edge.
    assign start_det = ~sda_f & sda_prev_q & scl_f & scl_prev_q;
    assign stop_det  = sda_f & ~sda_prev_q & scl_f & scl_prev_q;
    assign byte_in   = {shift_q[6:0], sda_f};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        setup_cnt_d  = setup_cnt_q;
        rw_d         = rw_q;
        scl_oen_d    = scl_oen_q;
        sda_oen_d    = sda_oen_q;
        tx_req_d     = tx_req_q;
        loaded_d     = loaded_q;
        ack_phase_d  = ack_phase_q;
        rx_valid_d   = 1'b0;
        addr_match_d = 1'b0;
        stop_d       = 1'b0;
        nack_d       = 1'b0;
        busy_d       = start_det ? 1'b1 : (stop_det ? 1'b0 : busy_q);

        if (!enable_i || start_det || stop_det) begin
            state_d   = (enable_i && start_det) ? StAddr : StIdle;
            bit_cnt_d = '0;
            scl_oen_d = OenRelease;
            sda_oen_d = OenRelease;
            tx_req_d  = 1'b0;
            loaded_d  = 1'b0;
            stop_d    = enable_i && !start_det;
        end else begin
            case (state_q)
                StIdle: ;
                StAddr: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (addr_hit(byte_in, own_addr_i)) begin
                            rw_d         = byte_in[0];
                            addr_match_d = 1'b1;
                            ack_phase_d  = 1'b0;
                            state_d      = StAddrAck;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StAddrAck: if (scl_fall) begin
                    ack_phase_d = 1'b1;
                    sda_oen_d   = ack_phase_q ? OenRelease : OenDrive;
                    if (ack_phase_q) begin
                        bit_cnt_d = '0;
                        state_d   = rw_q ? StTxWait : StRx;
                    end
                end
                StRx: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d   = byte_in;
                        rx_valid_d  = 1'b1;
                        ack_phase_d = 1'b0;
                        state_d     = StRxAck;
                    end
                end
                StRxAck: if (scl_fall) begin
                    ack_phase_d = 1'b1;
                    sda_oen_d   = (host_io.ack_en && !ack_phase_q) ? OenDrive : OenRelease;
                    if (ack_phase_q) begin
                        bit_cnt_d = '0;
                        state_d   = StRx;
                    end
                end
                StTxWait: begin
                    if (!loaded_q) begin
                        scl_oen_d = OenDrive;
                        tx_req_d  = 1'b1;
                        if (host_io.tx_valid && tx_req_q) begin
                            shift_d     = host_io.tx_data;
                            sda_oen_d   = host_io.tx_data[7];
                            tx_req_d    = 1'b0;
                            loaded_d    = 1'b1;
                            setup_cnt_d = '0;
                        end
                    end else if (setup_cnt_q == SetupW'(SETUP_CNT - 1)) begin
                        scl_oen_d = OenRelease;
                        loaded_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = StTx;
                    end else begin
                        setup_cnt_d = setup_cnt_q + SetupW'(1);
                    end
                end
                StTx: if (scl_fall) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    sda_oen_d = shift_q[6];
                    if (bit_cnt_q == 3'd7) begin
                        sda_oen_d   = OenRelease;
                        ack_phase_d = 1'b0;
                        state_d     = StTxAck;
                    end
                end
                StTxAck: begin
                    if (scl_rise && !ack_phase_q) begin
                        if (sda_f) begin
                            nack_d    = 1'b1;
                            sda_oen_d = OenRelease;
                            state_d   = StIdle;
                        end else begin
                            ack_phase_d = 1'b1;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        state_d = StTxWait;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sysclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            setup_cnt_q  <= '0;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            scl_oen_q    <= OenRelease;
            sda_oen_q    <= OenRelease;
            tx_req_q     <= 1'b0;
            loaded_q     <= 1'b0;
            ack_phase_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            stop_q       <= 1'b0;
            nack_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            setup_cnt_q  <= setup_cnt_d;
            scl_prev_q   <= scl_f;
            sda_prev_q   <= sda_f;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            scl_oen_q    <= scl_oen_d;
            sda_oen_q    <= sda_oen_d;
            tx_req_q     <= tx_req_d;
            loaded_q     <= loaded_d;
            ack_phase_q  <= ack_phase_d;
            rx_valid_q   <= rx_valid_d;
            addr_match_q <= addr_match_d;
            stop_q       <= stop_d;
            nack_q       <= nack_d;
        end
    end

    assign scl_oen_o           = scl_oen_q;
    assign sda_oen_o           = sda_oen_q;
    assign host_io.rx_data     = rx_data_q;
    assign host_io.rx_valid    = rx_valid_q;
    assign host_io.tx_req      = tx_req_q;
    assign host_io.addr_match  = addr_match_q;
    assign host_io.rw          = rw_q;
    assign host_io.busy        = busy_q;
    assign host_io.stop        = stop_q;
    assign host_io.master_nack = nack_q;

endmodule

// File: tb/tb_i2c_target_ctl.sv
// Scoreboarded bench for i2c_target_ctl: a bus-master model drives open-drain
// SCL/SDA, expected host events are queued and a monitor checks them in order.
module tb_i2c_target_ctl;

    localparam int HALF      = 20;
    localparam int SETUP_CNT = 4;

    typedef enum logic [3:0] {EvAddr, EvRx, EvStop, EvNack, EvTxReq} ev_e;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic [6:0] own_addr = 7'h50;
    logic       m_scl = 1'b1, m_sda = 1'b1;
    logic       scl_oen, sda_oen, scl_line, sda_line;
    logic       sda_drv_seen = 1'b0;
    logic       tx_req_prev = 1'b0;
    int         total = 0, bad = 0;
    logic [11:0] exp_q [$];

    i2c_target_ctl_if host ();

    assign scl_line = m_scl & scl_oen;
    assign sda_line = m_sda & sda_oen;

    i2c_target_ctl #(.FILT_LEN(3), .SETUP_CNT(SETUP_CNT)) dut (
        .sysclk_i  (clk),
        .reset_n_i (reset_n),
        .enable_i  (enable),
        .own_addr_i(own_addr),
        .scl_i     (scl_line),
        .scl_oen_o (scl_oen),
        .sda_i     (sda_line),
        .sda_oen_o (sda_oen),
        .host_io   (host)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_e k, input logic [7:0] d);
        exp_q.push_back({k, d});
    endtask

    task automatic sb(input ev_e k, input logic [7:0] d);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got %0h expected none at %0t", {k, d}, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event", {20'h0, k, d}, {20'h0, e});
        end
    endtask

    // Monitor: every host-visible event is matched against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                tx_req_prev = 1'b0;
            end else begin
                if (host.addr_match)  sb(EvAddr, {7'h0, host.rw});
                if (host.rx_valid)    sb(EvRx, host.rx_data);
                if (host.stop)        sb(EvStop, {7'h0, host.busy});
                if (host.master_nack) sb(EvNack, {7'h0, sda_oen});
                if (host.tx_req && !tx_req_prev) sb(EvTxReq, {7'h0, scl_oen});
                tx_req_prev = host.tx_req;
                if (!sda_oen) sda_drv_seen = 1'b1;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_up();
        int n = 0;
        m_scl = 1'b1;
        while (scl_line !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL scl_release: got 0 expected 1 within 1000 cycles");
        end
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;
        cyc(HALF);
        scl_up();
        cyc(HALF);
        m_scl = 1'b0;
        cyc(4);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1;
        cyc(HALF);
        scl_up();
        cyc(HALF / 2);
        b = sda_line;
        cyc(HALF / 2);
        m_scl = 1'b0;
        cyc(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_bits(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b0;
        cyc(HALF);
        m_scl = 1'b0;
        cyc(HALF);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1;
        cyc(HALF);
        scl_up();
        cyc(HALF);
        i2c_start();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        cyc(HALF);
        scl_up();
        cyc(HALF);
        m_sda = 1'b1;
        cyc(HALF);
    endtask

    // Host side: wait for the stretch request, then supply a byte after dly cycles.
    task automatic host_feed(input logic [7:0] d, input int dly);
        int n = 0;
        while (!host.tx_req && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_req_seen", host.tx_req, 1);
        cyc(dly);
        chk("scl_stretched", scl_line, 0);
        host.tx_data  = d;
        host.tx_valid = 1'b1;
        @(negedge clk);
        host.tx_valid = 1'b0;
        n = 0;
        while (!scl_oen && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("setup_cycles", n, SETUP_CNT);
        chk("sda_at_release", sda_oen, d[7]);
    endtask

    logic       ack;
    logic [7:0] d;

    initial begin
        host.ack_en   = 1'b1;
        host.tx_data  = 8'h00;
        host.tx_valid = 1'b0;
        cyc(5);
        chk("rst_scl_oen", scl_oen, 1);
        chk("rst_sda_oen", sda_oen, 1);
        reset_n = 1'b1;
        cyc(10);
        chk("rst_rx_data", host.rx_data, 0);
        chk("rst_rw", host.rw, 0);
        chk("rst_busy", host.busy, 0);
        chk("rst_tx_req", host.tx_req, 0);

        // 1: write A0, 3C, STOP
        push(EvAddr, 8'h00); push(EvRx, 8'h3C); push(EvStop, 8'h00);
        i2c_start();
        write_byte(8'hA0, ack); chk("t1_addr_ack", ack, 0);
        write_byte(8'h3C, ack); chk("t1_data_ack", ack, 0);
        i2c_stop();
        cyc(20);
        chk("t1_busy", host.busy, 0);
        chk("t1_rx_data", host.rx_data, 8'h3C);

        // 2: foreign address, never driven
        sda_drv_seen = 1'b0;
        push(EvStop, 8'h00);
        i2c_start();
        write_byte(8'hA2, ack); chk("t2_addr_nack", ack, 1);
        i2c_stop();
        cyc(20);
        chk("t2_no_drive", sda_drv_seen, 0);

        // 3: read 96 with stretch, master NACK
        push(EvAddr, 8'h01); push(EvTxReq, 8'h00); push(EvNack, 8'h01); push(EvStop, 8'h00);
        i2c_start();
        write_byte(8'hA1, ack); chk("t3_addr_ack", ack, 0);
        fork
            read_bits(d);
            host_feed(8'h96, 50);
        join
        chk("t3_tx_byte", d, 8'h96);
        write_bit(1'b1);
        i2c_stop();
        cyc(20);

        // 4: write 11, repeated START, read
        push(EvAddr, 8'h00); push(EvRx, 8'h11); push(EvAddr, 8'h01); push(EvTxReq, 8'h00);
        push(EvNack, 8'h01); push(EvStop, 8'h00);
        i2c_start();
        write_byte(8'hA0, ack); chk("t4_addr_ack", ack, 0);
        write_byte(8'h11, ack); chk("t4_data_ack", ack, 0);
        i2c_rstart();
        chk("t4_busy_rs", host.busy, 1);
        write_byte(8'hA1, ack); chk("t4_raddr_ack", ack, 0);
        cyc(10);
        chk("t4_rx_data", host.rx_data, 8'h11);
        chk("t4_rw", host.rw, 1);
        chk("t4_tx_req", host.tx_req, 1);
        fork
            read_bits(d);
            host_feed(8'h5A, 10);
        join
        chk("t4_tx_byte", d, 8'h5A);
        chk("t4_busy_tx", host.busy, 1);
        write_bit(1'b1);
        i2c_stop();
        cyc(20);

        // 5: 1-cycle SDA glitch with SCL high, then NACKed write
        @(negedge clk) m_sda = 1'b0;
        @(negedge clk) m_sda = 1'b1;
        cyc(30);
        chk("t5_glitch_busy", host.busy, 0);
        host.ack_en = 1'b0;
        push(EvAddr, 8'h00); push(EvRx, 8'h7E); push(EvStop, 8'h00);
        i2c_start();
        write_byte(8'hA0, ack); chk("t5_addr_ack", ack, 0);
        write_byte(8'h7E, ack); chk("t5_data_nack", ack, 1);
        i2c_stop();
        host.ack_en = 1'b1;
        cyc(20);

        // 6: reset in the TX ACK slot, then recovery on the next START
        push(EvAddr, 8'h01); push(EvTxReq, 8'h00);
        i2c_start();
        write_byte(8'hA1, ack); chk("t6_addr_ack", ack, 0);
        fork
            read_bits(d);
            host_feed(8'hC3, 10);
        join
        chk("t6_tx_byte", d, 8'hC3);
        m_sda = 1'b1;
        cyc(8);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_scl_oen", scl_oen, 1);
        chk("t6_rst_sda_oen", sda_oen, 1);
        chk("t6_rst_rw", host.rw, 0);
        chk("t6_rst_rx_data", host.rx_data, 0);
        cyc(3);
        reset_n = 1'b1;
        cyc(10);
        write_bit(1'b0);
        write_byte(8'hA0, ack); chk("t6_ignored", ack, 1);
        push(EvAddr, 8'h00); push(EvRx, 8'h42); push(EvStop, 8'h00);
        i2c_rstart();
        write_byte(8'hA0, ack); chk("t6_addr_ack2", ack, 0);
        write_byte(8'h42, ack); chk("t6_data_ack2", ack, 0);
        i2c_stop();
        cyc(20);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
